dbg_burst_xfer: RTL and testbench

DBG_BURST_XFER -- requirements
Module: dbg_burst_xfer

---
 rtl/dbg_burst_pkg.sv | 22 ++
 rtl/dbg_burst_fifo.sv | 52 +++++
 rtl/dbg_burst_xfer.sv | 173 +++++++++++++++++
 tb/tb_dbg_burst_xfer.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_burst_pkg.sv
// Shared types and defaults for the debug burst transfer engine.
// Optional checksum output is enabled by defining DBG_BURST_CHECKSUM_EN.
package dbg_burst_pkg;

  localparam int ADDR_WIDTH_DEF    = 32;
  localparam int DATA_WIDTH_DEF    = 32;
  localparam int LEN_WIDTH_DEF     = 8;
  localparam int RD_FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR    = 2'd1,
    RD    = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Number of address bits that select a byte within one beat.
  function automatic int byte_off_w(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/dbg_burst_fifo.sv
// Synchronous read-data FIFO with occupancy output; DEPTH must be a power of two.
// Output data reads as zero while empty so the read port is quiet after reset.
module dbg_burst_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty_o    = (count == '0);
  assign full_o     = (count == CNT_W'(DEPTH));
  assign count_o    = count;
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = empty_o ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/dbg_burst_xfer.sv
// Debug burst engine: turns one read/write burst command into single-beat memory requests.
// Defining DBG_BURST_CHECKSUM_EN adds checksum_o, the running beat sum of the current command.
module dbg_burst_xfer
  import dbg_burst_pkg::*;
#(
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH     = LEN_WIDTH_DEF,
  parameter int RD_FIFO_DEPTH = RD_FIFO_DEPTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  // All streams use valid/ready: a transfer happens on a rising edge where both are 1;
  // a source holds valid and payload stable until then. mem_req/mem_gnt behave the same way.
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rdata_valid_o,
  input  logic                  rdata_ready_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_err_i,
  output logic                  done_o,
  output logic                  err_o,
  output state_e                state_o
`ifdef DBG_BURST_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum_o
`endif
);

  localparam int OFF_W = byte_off_w(DATA_WIDTH);
  localparam int STEP  = DATA_WIDTH / 8;
  localparam int OUT_W = $clog2(RD_FIFO_DEPTH + 1);
  localparam int SUM_W = OUT_W + 1;
  localparam logic [LEN_WIDTH:0] ONE_BEAT = {{LEN_WIDTH{1'b0}}, 1'b1};

  state_e                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH:0]    beats;
  logic [OUT_W-1:0]      outstanding;
  logic                  rd_mode;
  logic                  err_q;
  logic                  done_q;

  logic                  grant;
  logic                  rsp_ok;
  logic                  rd_room;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [OUT_W-1:0]      fifo_count;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  addr_lsb_unused;

  assign addr_lsb_unused = ^cmd_addr_i[OFF_W-1:0];

  // Issued-but-unanswered reads plus buffered beats never exceed the FIFO depth.
  assign rd_room = (SUM_W'(outstanding) + SUM_W'(fifo_count)) < SUM_W'(RD_FIFO_DEPTH);

  always_comb begin
    mem_req_o = 1'b0;
    case (state)
      WR:      mem_req_o = wdata_valid_i && (beats != '0);
      RD:      mem_req_o = (beats != '0) && rd_room;
      default: mem_req_o = 1'b0;
    endcase
  end

  assign grant     = mem_req_o && mem_gnt_i;
  // A response with nothing outstanding is stale (e.g. issued before reset).
  assign rsp_ok    = mem_rvalid_i && (outstanding != '0);
  assign fifo_push = rsp_ok && rd_mode && !fifo_full;
  assign fifo_pop  = rdata_ready_i && !fifo_empty;

  assign cmd_ready_o   = (state == IDLE);
  assign wdata_ready_o = (state == WR) && grant;
  assign mem_we_o      = (state == WR);
  assign mem_addr_o    = addr;
  assign mem_wdata_o   = (state == WR) ? wdata_i : '0;
  assign rdata_valid_o = !fifo_empty;
  assign rdata_o       = fifo_rdata;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign state_o       = state;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      beats       <= '0;
      outstanding <= '0;
      rd_mode     <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      outstanding <= outstanding + OUT_W'(grant) - OUT_W'(rsp_ok);
      if (rsp_ok && mem_err_i) err_q <= 1'b1;
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            state   <= cmd_we_i ? WR : RD;
            rd_mode <= !cmd_we_i;
            addr    <= {cmd_addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            beats   <= {1'b0, cmd_len_i} + ONE_BEAT;
            err_q   <= 1'b0;
          end
        end
        WR, RD: begin
          if (grant) begin
            addr  <= addr + ADDR_WIDTH'(STEP);
            beats <= beats - ONE_BEAT;
            if (beats == ONE_BEAT) state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((outstanding == '0) && (!rd_mode || fifo_empty)) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  dbg_burst_fifo #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(RD_FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .push_i     (fifo_push),
    .push_data_i(mem_rdata_i),
    .pop_i      (fifo_pop),
    .pop_data_o (fifo_rdata),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .count_o    (fifo_count)
  );

`ifdef DBG_BURST_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      csum <= '0;
    end else if ((state == IDLE) && cmd_valid_i) begin
      csum <= '0;
    end else if ((state == WR) && grant) begin
      csum <= csum + wdata_i;
    end else if (fifo_push) begin
      csum <= csum + mem_rdata_i;
    end
  end

  assign checksum_o = csum;
`endif

endmodule

// File: tb/tb_dbg_burst_xfer.sv
// Self-checking bench for dbg_burst_xfer with a randomized memory model and scoreboard queues.
// Checksum checks are compiled in when DBG_BURST_CHECKSUM_EN is defined.
module tb_dbg_burst_xfer;
  import dbg_burst_pkg::*;

  logic        clk_i;
  logic        rst_n;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_addr_i;
  logic [7:0]  cmd_len_i;
  logic        wdata_valid_i;
  logic        wdata_ready_o;
  logic [31:0] wdata_i;
  logic        rdata_valid_o;
  logic        rdata_ready_i;
  logic [31:0] rdata_o;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;
  logic        done_o;
  logic        err_o;
  state_e      state_o;
`ifdef DBG_BURST_CHECKSUM_EN
  logic [31:0] checksum_o;
`endif

  dbg_burst_xfer dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_we_i     (cmd_we_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_len_i    (cmd_len_i),
    .wdata_valid_i(wdata_valid_i),
    .wdata_ready_o(wdata_ready_o),
    .wdata_i      (wdata_i),
    .rdata_valid_o(rdata_valid_o),
    .rdata_ready_i(rdata_ready_i),
    .rdata_o      (rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_err_i    (mem_err_i),
    .done_o       (done_o),
    .err_o        (err_o),
    .state_o      (state_o)
`ifdef DBG_BURST_CHECKSUM_EN
    ,
    .checksum_o   (checksum_o)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  int gnt_pct = 100;
  int rready_pct = 100;
  int wvalid_pct = 100;
  int rsp_min = 0;
  int rsp_max = 1;
  int err_beat = -1;

  logic [31:0] exp_q[$];
  logic [64:0] exp_gnt_q[$];
  logic [31:0] wsrc_q[$];
  logic [31:0] pend_data_q[$];
  logic        pend_err_q[$];
  int          pend_due_q[$];

  int          grant_cnt = 0;
  int          total_grants = 0;
  int          pop_cnt = 0;
  int          last_due = 0;
  logic        w_fire = 1'b0;
  logic [31:0] exp_sum = '0;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // Clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // Memory-side and stream drivers: all inputs change on the falling edge.
  initial begin
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
    wdata_valid_i = 1'b0; wdata_i = '0; rdata_ready_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (w_fire) begin
        if (wsrc_q.size() > 0) void'(wsrc_q.pop_front());
        wdata_valid_i = 1'b0;
        w_fire = 1'b0;
      end
      mem_gnt_i = ($urandom_range(99) < gnt_pct);
      if (pend_due_q.size() > 0 && cyc >= pend_due_q[0]) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = pend_data_q.pop_front();
        mem_err_i    = pend_err_q.pop_front();
        void'(pend_due_q.pop_front());
      end else begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
        mem_err_i    = 1'($urandom_range(1));
      end
      rdata_ready_i = ($urandom_range(99) < rready_pct);
      if (!wdata_valid_i && wsrc_q.size() > 0 && $urandom_range(99) < wvalid_pct) begin
        wdata_valid_i = 1'b1;
        wdata_i = wsrc_q[0];
      end
    end
  end

  // Scoreboard: samples just before each rising edge.
  initial begin : sampler
    logic [64:0] e;
    logic [64:0] got;
    logic [31:0] ed;
    int due;
    forever begin
      @(negedge clk_i);
      #4;
      if (mem_req_o && mem_gnt_i) begin
        n_vec++;
        got = {mem_we_o, mem_addr_o, mem_we_o ? mem_wdata_o : 32'h0};
        if (exp_gnt_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_grant: got %h required no request", got);
        end else begin
          e = exp_gnt_q.pop_front();
          if (got !== e) begin
            n_err++;
            $display("FAIL grant_fields: got we/addr/wdata %h required %h", got, e);
          end
        end
        due = cyc + 1 + int'($urandom_range(rsp_max, rsp_min));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_due_q.push_back(due);
        pend_data_q.push_back(mem_we_o ? 32'h0 : rd_fn(mem_addr_o));
        pend_err_q.push_back(grant_cnt == err_beat);
        grant_cnt++;
        total_grants++;
      end
      w_fire = wdata_valid_i && wdata_ready_o;
      if (rdata_valid_o && rdata_ready_i) begin
        n_vec++;
        pop_cnt++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_rdata: got %h required no beat", rdata_o);
        end else begin
          ed = exp_q.pop_front();
          if (rdata_o !== ed) begin
            n_err++;
            $display("FAIL rdata: got %h required %h", rdata_o, ed);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic issue_cmd(input logic we, input logic [31:0] addr, input int len,
                           input logic [31:0] wseed);
    logic [31:0] a;
    logic [31:0] d;
    logic ok;
    a = addr & 32'hFFFF_FFFC;
    grant_cnt = 0;
    exp_sum = '0;
    for (int i = 0; i <= len; i++) begin
      if (we) begin
        d = wseed ^ (i * 32'h1357_9BDF);
        wsrc_q.push_back(d);
        exp_gnt_q.push_back({1'b1, a, d});
        exp_sum += d;
      end else begin
        exp_gnt_q.push_back({1'b0, a, 32'h0});
        exp_q.push_back(rd_fn(a));
        exp_sum += rd_fn(a);
      end
      a = a + 32'd4;
    end
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    cmd_we_i = we;
    cmd_addr_i = addr;
    cmd_len_i = len[7:0];
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      #4;
      if (cmd_ready_o) ok = 1'b1;
      @(negedge clk_i);
      if (ok) break;
    end
    cmd_valid_i = 1'b0;
    cmd_addr_i = $urandom;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL cmd_accept: got ready 0 required 1 within 200 cycles");
    end
  endtask

  task automatic wait_done(input string tag, input logic exp_err, input int budget);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      #4;
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s_done: got no done pulse required one within %0d cycles", tag, budget);
      @(negedge clk_i);
      return;
    end
    n_vec++;
    if (err_o !== exp_err) begin
      n_err++;
      $display("FAIL %s_err: got %b required %b", tag, err_o, exp_err);
    end
    n_vec++;
    if (exp_q.size() != 0 || exp_gnt_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_leftover: got %0d beats/%0d grants pending required 0/0",
               tag, exp_q.size(), exp_gnt_q.size());
    end
    n_vec++;
    if (cmd_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s_ready_at_done: got %b required 1", tag, cmd_ready_o);
    end
`ifdef DBG_BURST_CHECKSUM_EN
    n_vec++;
    if (checksum_o !== exp_sum) begin
      n_err++;
      $display("FAIL %s_checksum: got %h required %h", tag, checksum_o, exp_sum);
    end
`endif
    @(negedge clk_i);
    #4;
    n_vec++;
    if (done_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s_done_width: got %b required 0", tag, done_o);
    end
    @(negedge clk_i);
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_i);
    #4;
    n_vec++;
    if ({cmd_ready_o, mem_req_o, mem_we_o, wdata_ready_o, rdata_valid_o, done_o, err_o} !== 7'b1000000) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b required 1000000",
               {cmd_ready_o, mem_req_o, mem_we_o, wdata_ready_o, rdata_valid_o, done_o, err_o});
    end
    n_vec++;
    if ({mem_addr_o, mem_wdata_o, rdata_o} !== 96'h0 || state_o !== IDLE) begin
      n_err++;
      $display("FAIL reset_data: got addr %h wdata %h rdata %h state %0d required zeros/IDLE",
               mem_addr_o, mem_wdata_o, rdata_o, state_o);
    end
    @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_single_write();
    int g0;
    gnt_pct = 100; rsp_min = 0; rsp_max = 1; wvalid_pct = 100; rready_pct = 100;
    g0 = total_grants;
    issue_cmd(1'b1, 32'h0000_0000, 0, 32'hABBA_ABBA);
    wait_done("single_write", 1'b0, 100);
    n_vec++;
    if (total_grants - g0 != 1) begin
      n_err++;
      $display("FAIL single_write_grants: got %0d required 1", total_grants - g0);
    end
  endtask

  task automatic test_read_backpressure();
    int g0;
    int p0;
    gnt_pct = 100; rsp_min = 0; rsp_max = 1; rready_pct = 0;
    g0 = total_grants;
    p0 = pop_cnt;
    issue_cmd(1'b0, 32'h0000_1000, 7, 32'h0);
    repeat (30) @(negedge clk_i);
    #4;
    n_vec++;
    if (total_grants - g0 != 4) begin
      n_err++;
      $display("FAIL backpressure_grants: got %0d required 4", total_grants - g0);
    end
    n_vec++;
    if (mem_req_o !== 1'b0 || rdata_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL backpressure_stall: got req %b rvalid %b required 0 1", mem_req_o, rdata_valid_o);
    end
    @(negedge clk_i);
    rready_pct = 100;
    wait_done("read_backpressure", 1'b0, 200);
    n_vec++;
    if (pop_cnt - p0 != 8) begin
      n_err++;
      $display("FAIL backpressure_beats: got %0d required 8", pop_cnt - p0);
    end
  endtask

  task automatic test_addr_wrap();
    gnt_pct = 70; rsp_min = 0; rsp_max = 2; wvalid_pct = 80;
    issue_cmd(1'b1, 32'hFFFF_FFFE, 1, 32'h1234_5678);
    wait_done("addr_wrap", 1'b0, 200);
  endtask

  task automatic test_long_read_err();
    int p0;
    gnt_pct = 60; rsp_min = 0; rsp_max = 3; rready_pct = 70; err_beat = 10;
    p0 = pop_cnt;
    issue_cmd(1'b0, 32'h2000_0103, 255, 32'h0);
    wait_done("long_read", 1'b1, 5000);
    err_beat = -1;
    n_vec++;
    if (pop_cnt - p0 != 256) begin
      n_err++;
      $display("FAIL long_read_beats: got %0d required 256", pop_cnt - p0);
    end
    #4;
    n_vec++;
    if (err_o !== 1'b1) begin
      n_err++;
      $display("FAIL err_sticky: got %b required 1", err_o);
    end
    @(negedge clk_i);
    gnt_pct = 50; rsp_min = 0; rsp_max = 2; wvalid_pct = 60;
    issue_cmd(1'b1, 32'h0000_0800, 2, 32'hC0FF_EE00);
    #4;
    n_vec++;
    if (err_o !== 1'b0) begin
      n_err++;
      $display("FAIL err_clear: got %b required 0", err_o);
    end
    @(negedge clk_i);
    wait_done("after_err_write", 1'b0, 300);
  endtask

  task automatic test_reset_mid();
    int p0;
    logic ok;
    gnt_pct = 100; rsp_min = 6; rsp_max = 8; rready_pct = 100;
    p0 = pop_cnt;
    issue_cmd(1'b0, 32'h0000_3000, 7, 32'h0);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk_i);
      if (pop_cnt - p0 >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL reset_mid_beats: got %0d beats required 2", pop_cnt - p0);
    end
    rst_n = 1'b0;
    exp_q.delete();
    exp_gnt_q.delete();
    #4;
    n_vec++;
    if ({cmd_ready_o, mem_req_o, mem_we_o, wdata_ready_o, rdata_valid_o, done_o, err_o} !== 7'b1000000) begin
      n_err++;
      $display("FAIL reset_mid_ctrl: got %b required 1000000",
               {cmd_ready_o, mem_req_o, mem_we_o, wdata_ready_o, rdata_valid_o, done_o, err_o});
    end
    n_vec++;
    if ({mem_addr_o, mem_wdata_o, rdata_o} !== 96'h0 || state_o !== IDLE) begin
      n_err++;
      $display("FAIL reset_mid_data: got addr %h wdata %h rdata %h state %0d required zeros/IDLE",
               mem_addr_o, mem_wdata_o, rdata_o, state_o);
    end
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
    for (int i = 0; i < pend_err_q.size(); i++) pend_err_q[i] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #4;
      n_vec++;
      if ({rdata_valid_o, err_o, mem_req_o, done_o} !== 4'b0000) begin
        n_err++;
        $display("FAIL stale_rsp: got rvalid/err/req/done %b required 0000",
                 {rdata_valid_o, err_o, mem_req_o, done_o});
      end
      @(negedge clk_i);
    end
    gnt_pct = 80; rsp_min = 0; rsp_max = 2; wvalid_pct = 90;
    issue_cmd(1'b1, 32'h0000_0040, 3, 32'h0BAD_F00D);
    wait_done("post_reset_write", 1'b0, 200);
  endtask

  // Sequencer and final report
  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single_write();
    test_read_backpressure();
    test_addr_wrap();
    test_long_read_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
